// File: rtl/pio_mailbox_bridge.sv
// pio_mailbox_bridge
//   Bridges four Nios PIO exports (cmd, wdata, rdata, status) to N_CHAN
//   accelerator channels. Software raises a request by toggling pio_cmd[31];
//   the bridge answers by toggling pio_status[31]. Writes are posted through
//   a FIFO; reads are queued the same way and then block until the
//   accelerator strobes acc_rvalid or the read timeout expires.
//
//   Ports
//     clk_clk, reset_reset    clock, synchronous active-high reset
//     pio_cmd                 [31] req toggle, [30] rnw, [29] ctrl,
//                             [ADDR_W+CH_W-1:ADDR_W] chan, [ADDR_W-1:0] addr
//     pio_wdata               write data (stable before the req toggle)
//     pio_rdata               read result (all ones after a timeout)
//     pio_status              [31] ack, [30] error, [29] busy,
//                             [15:8] fifo level, [7:0] sticky done flags
//     acc_valid/ready         command handshake, fields acc_chan/rnw/addr/wdata
//     acc_rvalid/rdata        one-cycle read-data return
//     acc_done                per-channel completion pulses

// One sticky done flag; set has priority over a same-cycle clear.
module pio_mailbox_done_bit (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic set,
    input  logic clr,
    output logic flag
);
    always_ff @(posedge clk_clk) begin
        if (reset_reset) flag <= 1'b0;
        else if (set)    flag <= 1'b1;
        else if (clr)    flag <= 1'b0;
    end
endmodule

module pio_mailbox_bridge #(
    parameter  int DATA_W     = 32,
    parameter  int ADDR_W     = 8,
    parameter  int N_CHAN     = 2,
    parameter  int FIFO_DEPTH = 8,
    parameter  int TIMEOUT    = 1023,
    localparam int CH_W       = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [31:0]       pio_cmd,
    input  logic [DATA_W-1:0] pio_wdata,
    output logic [DATA_W-1:0] pio_rdata,
    output logic [31:0]       pio_status,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [CH_W-1:0]   acc_chan,
    output logic              acc_rnw,
    output logic [ADDR_W-1:0] acc_addr,
    output logic [DATA_W-1:0] acc_wdata,
    input  logic              acc_rvalid,
    input  logic [DATA_W-1:0] acc_rdata,
    input  logic [N_CHAN-1:0] acc_done
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [CH_W-1:0]   chan;
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ENQ, RD_WAIT} state_t;

    // Registered PIO inputs (only the fields that are decoded).
    logic              req_q, rnw_q, ctrl_q;
    logic [CH_W-1:0]   chan_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Reserved cmd bits are ignored; the reduction keeps them visibly consumed.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^pio_cmd;

    state_t            state, state_nxt;
    logic              req_seen, ack, err;
    logic [DATA_W-1:0] rdata_q;
    logic [TO_W-1:0]   to_cnt;

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [7:0]        level;

    logic [N_CHAN-1:0] done_flags;

    // FSM controls
    logic              push, finish, done_clr, rd_load, set_err;
    logic [DATA_W-1:0] rd_val;

    logic req, empty, full, pop, can_push;
    assign req      = req_q ^ req_seen;
    assign empty    = (level == 8'd0);
    assign full     = (level == 8'(FIFO_DEPTH));
    assign pop      = !empty && acc_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign can_push = !full || pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        finish    = 1'b0;
        done_clr  = 1'b0;
        rd_load   = 1'b0;
        rd_val    = acc_rdata;
        set_err   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (ctrl_q) begin
                        done_clr = 1'b1;
                        finish   = 1'b1;
                    end else if (can_push) begin
                        push = 1'b1;
                        if (rnw_q) state_nxt = RD_WAIT;
                        else       finish    = 1'b1;
                    end else begin
                        state_nxt = ENQ;
                    end
                end
            end
            ENQ: begin
                if (can_push) begin
                    push = 1'b1;
                    if (rnw_q) state_nxt = RD_WAIT;
                    else begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                if (acc_rvalid) begin
                    rd_load   = 1'b1;
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    rd_load   = 1'b1;
                    rd_val    = '1;
                    set_err   = 1'b1;
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            req_q    <= 1'b0;
            rnw_q    <= 1'b0;
            ctrl_q   <= 1'b0;
            chan_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            state    <= IDLE;
            req_seen <= 1'b0;
            ack      <= 1'b0;
            err      <= 1'b0;
            rdata_q  <= '0;
            to_cnt   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else begin
            req_q   <= pio_cmd[31];
            rnw_q   <= pio_cmd[30];
            ctrl_q  <= pio_cmd[29];
            chan_q  <= pio_cmd[ADDR_W+CH_W-1:ADDR_W];
            addr_q  <= pio_cmd[ADDR_W-1:0];
            wdata_q <= pio_wdata;
            state   <= state_nxt;
            if (finish) begin
                ack      <= ~ack;
                req_seen <= ~req_seen;
            end
            if (done_clr)     err <= 1'b0;
            else if (set_err) err <= 1'b1;
            if (rd_load) rdata_q <= rd_val;
            // Counter restarts at 0 on every RD_WAIT entry.
            to_cnt <= (state == RD_WAIT) ? to_cnt + 1'b1 : '0;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            level <= level + 8'(push) - 8'(pop);
        end
    end

    // Storage needs no reset: entries are only visible while level != 0.
    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_ptr] <= '{chan: chan_q, rnw: rnw_q, addr: addr_q, wdata: wdata_q};
    end

    entry_t head;
    assign head      = empty ? '0 : mem[rd_ptr];
    assign acc_valid = !empty;
    assign acc_chan  = head.chan;
    assign acc_rnw   = head.rnw;
    assign acc_addr  = head.addr;
    assign acc_wdata = head.wdata;

    pio_mailbox_done_bit u_done [N_CHAN-1:0] (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .set         (acc_done),
        .clr         (done_clr),
        .flag        (done_flags)
    );

    logic busy;
    assign busy       = (state != IDLE) || !empty;
    assign pio_rdata  = rdata_q;
    assign pio_status = {ack, err, busy, 13'd0, level, 8'(done_flags)};
endmodule

// File: tb/tb_pio_mailbox_bridge.sv
module tb_pio_mailbox_bridge;
    localparam int DATA_W = 32, ADDR_W = 8, N_CHAN = 2, FIFO_DEPTH = 8, TIMEOUT = 1023;
    localparam int CH_W = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [31:0]       pio_cmd;
    logic [DATA_W-1:0] pio_wdata, pio_rdata;
    logic [31:0]       pio_status;
    logic              acc_valid, acc_ready, acc_rnw, acc_rvalid;
    logic [CH_W-1:0]   acc_chan;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata, acc_rdata;
    logic [N_CHAN-1:0] acc_done;

    pio_mailbox_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CHAN(N_CHAN),
                         .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_clk(clk), .reset_reset(rst), .pio_cmd(pio_cmd), .pio_wdata(pio_wdata),
        .pio_rdata(pio_rdata), .pio_status(pio_status), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .acc_chan(acc_chan), .acc_rnw(acc_rnw),
        .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_rvalid(acc_rvalid),
        .acc_rdata(acc_rdata), .acc_done(acc_done)
    );

    // Reference model: commands software has issued, in the order the
    // accelerator must see them, plus the expected software-visible state.
    typedef struct packed {
        logic [CH_W-1:0]   chan;
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t     exp_q[$];
    int       checks = 0, errors = 0;
    bit       sw_req = 0, exp_ack = 0, exp_err = 0, rand_rdy = 0;
    bit [7:0] exp_done = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accelerator side: every accepted command must be the next one issued.
    always @(negedge clk) begin
        cmd_t got, want;
        if (rst === 1'b0 && acc_valid === 1'b1 && acc_ready === 1'b1) begin
            got = {acc_chan, acc_rnw, acc_addr, acc_wdata};
            check("cmd_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                check("acc_cmd", 64'(got), 64'(want));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_rdy) acc_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic issue(input bit ctrl, input bit rnw, input logic [CH_W-1:0] chan,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        pio_wdata = data;
        sw_req    = ~sw_req;
        pio_cmd   = '0;
        pio_cmd[31] = sw_req;
        pio_cmd[30] = rnw;
        pio_cmd[29] = ctrl;
        pio_cmd[ADDR_W+CH_W-1:ADDR_W] = chan;
        pio_cmd[ADDR_W-1:0] = addr;
        if (!ctrl) exp_q.push_back({chan, rnw, addr, data});
    endtask

    task automatic wait_ack(input string tag, input int max);
        int n = 0;
        while (pio_status[31] !== exp_ack && n < max) begin
            tick();
            n++;
        end
        check(tag, 64'(pio_status[31]), 64'(exp_ack));
    endtask

    task automatic do_write(input logic [CH_W-1:0] chan, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data);
        issue(0, 0, chan, addr, data);
        exp_ack = ~exp_ack;
        wait_ack("write_ack", 300);
    endtask

    task automatic do_read(input logic [CH_W-1:0] chan, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] resp, input int delay);
        int n = 0;
        issue(0, 1, chan, addr, $urandom);
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check("read_issued", 64'(exp_q.size()), 64'd0);
        tick(delay);
        check("read_blocks", 64'(pio_status[31]), 64'(exp_ack));
        check("read_busy", 64'(pio_status[29]), 64'd1);
        acc_rvalid = 1'b1;
        acc_rdata  = resp;
        tick();
        acc_rvalid = 1'b0;
        exp_ack    = ~exp_ack;
        check("read_ack", 64'(pio_status[31]), 64'(exp_ack));
        check("read_data", 64'(pio_rdata), 64'(resp));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (pio_status[15:8] != 8'd0 && n < 500) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        check({tag, "_level"}, 64'(pio_status[15:8]), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d;
        rst = 1; pio_cmd = '0; pio_wdata = '0; acc_ready = 0; acc_rvalid = 0;
        acc_rdata = '0; acc_done = '0;
        tick(3);
        check("rst_status", 64'(pio_status), 64'd0);
        check("rst_rdata", 64'(pio_rdata), 64'd0);
        check("rst_acc", 64'({acc_valid, acc_chan, acc_rnw, acc_addr, acc_wdata}), 64'd0);
        rst = 0;
        tick();

        // 1: single write, ack two cycles after the toggle, head presented.
        issue(0, 0, 1'b1, 8'h12, 32'hCAFEF00D);
        tick();
        check("wr_ack_early", 64'(pio_status[31]), 64'd0);
        tick();
        exp_ack = ~exp_ack;
        check("wr_ack_2cyc", 64'(pio_status[31]), 64'(exp_ack));
        check("wr_head", 64'({acc_valid, acc_chan, acc_rnw, acc_addr, acc_wdata}),
              64'({1'b1, 1'b1, 1'b0, 8'h12, 32'hCAFEF00D}));
        check("wr_level", 64'(pio_status[15:8]), 64'd1);
        tick(3);
        check("wr_head_held", 64'({acc_valid, acc_addr, acc_wdata}), 64'({1'b1, 8'h12, 32'hCAFEF00D}));
        acc_ready = 1;
        drain("wr_drain");

        // 2: fill the FIFO with ready low; the ninth write must wait.
        acc_ready = 0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            do_write(1'($urandom_range(0, N_CHAN - 1)), 8'($urandom), $urandom);
        issue(0, 0, 1'b0, 8'($urandom), $urandom);
        tick(6);
        check("full_no_ack", 64'(pio_status[31]), 64'(exp_ack));
        check("full_level", 64'(pio_status[15:8]), 64'(FIFO_DEPTH));
        check("full_busy", 64'(pio_status[29]), 64'd1);
        acc_ready = 1;
        exp_ack = ~exp_ack;
        wait_ack("full_late_ack", 20);
        drain("full_drain");
        check("full_idle", 64'(pio_status[29]), 64'd0);

        // 3: blocking read with a 20-cycle response.
        d = $urandom;
        do_read(1'b0, 8'h05, d, 20);
        tick(5);
        check("read_ack_once", 64'(pio_status[31]), 64'(exp_ack));
        check("read_not_busy", 64'(pio_status[29]), 64'd0);

        // Random mix with a randomly stalling accelerator.
        rand_rdy = 1;
        for (int it = 0; it < 24; it++) begin
            int op;
            logic [1:0] m;
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) begin
                m = 2'($urandom_range(1, 3));
                acc_done = m;
                tick();
                acc_done = '0;
                exp_done |= 8'(m);
            end
            if (op < 2) begin
                issue(1, 0, 1'b0, 8'h00, $urandom);
                exp_ack = ~exp_ack;
                wait_ack("ctrl_ack", 20);
                exp_done = 0;
                exp_err  = 0;
            end else if (op < 5) begin
                do_read(1'($urandom_range(0, N_CHAN - 1)), 8'($urandom), $urandom,
                        $urandom_range(0, 30));
            end else begin
                do_write(1'($urandom_range(0, N_CHAN - 1)), 8'($urandom), $urandom);
            end
            check("rnd_done", 64'(pio_status[7:0]), 64'(exp_done));
            check("rnd_err", 64'(pio_status[30]), 64'(exp_err));
            check("rnd_level", 64'(pio_status[15:8]), 64'(exp_q.size()));
        end
        rand_rdy = 0;
        acc_ready = 1;
        drain("rnd_drain");

        // 4: read timeout, 2 cycles to enqueue + TIMEOUT cycles waiting.
        issue(0, 1, 1'b1, 8'h33, $urandom);
        tick(TIMEOUT + 1);
        check("to_early", 64'(pio_status[31]), 64'(exp_ack));
        tick();
        exp_ack = ~exp_ack;
        check("to_ack", 64'(pio_status[31]), 64'(exp_ack));
        check("to_rdata", 64'(pio_rdata), 64'(32'hFFFF_FFFF));
        check("to_err", 64'(pio_status[30]), 64'd1);
        d = $urandom;
        do_read(1'b1, 8'h44, d, 3);
        check("to_err_sticky", 64'(pio_status[30]), 64'd1);
        issue(1, 0, 1'b0, 8'h00, 32'h0);
        exp_ack = ~exp_ack;
        wait_ack("to_clr_ack", 20);
        check("to_err_clr", 64'(pio_status[30]), 64'd0);

        // 5: done flags; a set coinciding with a clear survives it.
        acc_done = 2'b01;
        tick();
        acc_done = '0;
        check("done0_set", 64'(pio_status[7:0]), 64'h01);
        issue(1, 0, 1'b0, 8'h00, 32'h0);
        tick();
        acc_done = 2'b10;
        tick();
        acc_done = '0;
        exp_ack = ~exp_ack;
        check("done_clr_ack", 64'(pio_status[31]), 64'(exp_ack));
        check("done_set_wins", 64'(pio_status[7:0]), 64'h02);
        issue(1, 0, 1'b0, 8'h00, 32'h0);
        exp_ack = ~exp_ack;
        wait_ack("done_clr2_ack", 20);
        check("done_cleared", 64'(pio_status[7:0]), 64'h00);

        // 6: reset while a read waits behind three queued writes.
        acc_ready = 0;
        for (int i = 0; i < 3; i++) do_write(1'b1, 8'(i), $urandom);
        issue(0, 1, 1'b0, 8'h77, $urandom);
        tick(3);
        check("pre_rst_level", 64'(pio_status[15:8]), 64'd4);
        rst = 1;
        pio_cmd = '0;
        sw_req = 0;
        exp_ack = 0;
        exp_q.delete();
        tick(2);
        check("rst2_status", 64'(pio_status), 64'd0);
        check("rst2_rdata", 64'(pio_rdata), 64'd0);
        check("rst2_acc", 64'({acc_valid, acc_chan, acc_rnw, acc_addr, acc_wdata}), 64'd0);
        rst = 0;
        tick();
        acc_rvalid = 1;
        acc_rdata  = $urandom | 32'h1;
        tick();
        acc_rvalid = 0;
        tick(2);
        check("late_rvalid_rdata", 64'(pio_rdata), 64'd0);
        check("late_rvalid_status", 64'(pio_status), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
